multicycle_controller: RTL

Moore-style control FSM that sequences the shared multicycle RISC-V datapath, where one memory port and one ALU are reused across several cycles per instruction. It decodes `op_code` from the instruction register and steps through fetch, decode, execute, memory and writeback states. It drives every datapath mux select and write strobe, and stalls on a memory ready handshake. The `alu_op` it emits feeds the existing ALU decoder, which resolves funct3/funct7. Supported opcodes are LW, SW, BEQ, I_TYPE, R_TYPE and JAL; any other opcode halts the block in a trap state.

---
 rtl/multicycle_controller_if.sv | 56 +++++
 rtl/multicycle_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
// Bundles the control bus between the multicycle controller and the shared
// datapath / memory port.
//
// Signals (direction as seen from the controller, modport master):
//   op_code     in  7  opcode field of the instruction register
//   zero        in  1  ALU zero flag
//   mem_ready   in  1  memory accepted/completed the current request
//   mem_req     out 1  memory access request
//   mem_w       out 1  write qualifier for mem_req
//   adr_src     out 1  memory address mux (0 = PC, 1 = ALU result register)
//   ir_w        out 1  instruction register / old-PC register load
//   pc_w        out 1  PC load
//   reg_w       out 1  register file write
//   alu_src_a   out 2  ALU A mux (00 = PC, 01 = old PC, 10 = rs1)
//   alu_src_b   out 2  ALU B mux (00 = rs2, 01 = immediate, 10 = 4)
//   alu_op      out 2  ALU function class (00 add, 01 sub, 10 funct)
//   result_src  out 2  result mux (00 ALU reg, 01 mem data, 10 ALU direct)
//   imm_src     out 2  immediate format select
//   retire      out 1  final cycle of an instruction
//   trap        out 1  controller halted on an unsupported opcode
// The slave modport is the datapath/memory view of the same wires.
// -----------------------------------------------------------------------------
interface multicycle_controller_if;
  logic [6:0] op_code;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_w;
  logic       adr_src;
  logic       ir_w;
  logic       pc_w;
  logic       reg_w;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic       retire;
  logic       trap;

  modport master (
    input  op_code, zero, mem_ready,
    output mem_req, mem_w, adr_src, ir_w, pc_w, reg_w,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src,
           retire, trap
  );

  modport slave (
    output op_code, zero, mem_ready,
    input  mem_req, mem_w, adr_src, ir_w, pc_w, reg_w,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src,
           retire, trap
  );
endinterface

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Moore-style control FSM sequencing a multicycle RISC-V datapath that shares
// one memory port and one ALU across the cycles of each instruction. Supports
// LW, SW, BEQ, I_TYPE, R_TYPE and JAL; any other opcode parks the block in a
// trap state until reset.
//
// Ports:
//   clk    in  1  single clock, rising edge
//   rst_n  in  1  synchronous active-low reset
//   bus    multicycle_controller_if.master  opcode/flags in, controls out
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic                           clk,
  input  logic                           rst_n,
  multicycle_controller_if.master        bus
);

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BEQ    = 7'b1100011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_e;

  state_e state_q, state_d;

  logic       memReq, memW, adrSrc, irW, regW, retire, trap;
  logic       pcUpdate, branch, pcW;
  logic [1:0] aluSrcA, aluSrcB, aluOp, resultSrc, immSrc;

  // State register: reset is sampled on the clock edge and always restarts
  // at FETCH, which also abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The three memory-facing states hold until mem_ready;
  // every other state advances unconditionally.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op_code)
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_R_TYPE:    state_d = S_EXEC_R;
          OP_I_TYPE:    state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADR: begin
        // op_code is held stable after DECODE, so only LW/SW can reach here;
        // anything else is treated as a corrupted instruction.
        if (bus.op_code == OP_LW)      state_d = S_MEM_READ;
        else if (bus.op_code == OP_SW) state_d = S_MEM_WRITE;
        else                           state_d = S_TRAP;
      end
      S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      S_JAL:       state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BEQ:       state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;
    endcase
  end

  // Output decode. Everything is gated by rst_n so the datapath sees no
  // strobes while reset is held, even before the state register has loaded.
  // The FETCH write strobes and the MEM_WRITE retire wait for mem_ready so
  // they fire only in the cycle the transfer actually completes.
  always_comb begin
    memReq    = 1'b0;
    memW      = 1'b0;
    adrSrc    = 1'b0;
    irW       = 1'b0;
    regW      = 1'b0;
    retire    = 1'b0;
    trap      = 1'b0;
    pcUpdate  = 1'b0;
    branch    = 1'b0;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    resultSrc = 2'b00;
    immSrc    = 2'b00;
    if (rst_n) begin
      case (bus.op_code)
        OP_SW:   immSrc = 2'b01;
        OP_BEQ:  immSrc = 2'b10;
        OP_JAL:  immSrc = 2'b11;
        default: immSrc = 2'b00;
      endcase
      unique case (state_q)
        S_FETCH: begin
          memReq    = 1'b1;
          aluSrcB   = 2'b10;
          resultSrc = 2'b10;
          irW       = bus.mem_ready;
          pcUpdate  = bus.mem_ready;
        end
        S_DECODE: begin
          // Precompute old PC + immediate as the branch/jump target.
          aluSrcA = 2'b01;
          aluSrcB = 2'b01;
        end
        S_MEM_ADR: begin
          aluSrcA = 2'b10;
          aluSrcB = 2'b01;
        end
        S_MEM_READ: begin
          memReq = 1'b1;
          adrSrc = 1'b1;
        end
        S_MEM_WB: begin
          resultSrc = 2'b01;
          regW      = 1'b1;
          retire    = 1'b1;
        end
        S_MEM_WRITE: begin
          memReq = 1'b1;
          memW   = 1'b1;
          adrSrc = 1'b1;
          retire = bus.mem_ready;
        end
        S_EXEC_R: begin
          aluSrcA = 2'b10;
          aluOp   = 2'b10;
        end
        S_EXEC_I: begin
          aluSrcA = 2'b10;
          aluSrcB = 2'b01;
          aluOp   = 2'b10;
        end
        S_JAL: begin
          // Jump target comes from the ALU output register (DECODE result)
          // while the ALU forms old PC + 4 for the link write in ALU_WB.
          aluSrcA  = 2'b01;
          aluSrcB  = 2'b10;
          pcUpdate = 1'b1;
        end
        S_ALU_WB: begin
          regW   = 1'b1;
          retire = 1'b1;
        end
        S_BEQ: begin
          aluSrcA = 2'b10;
          aluOp   = 2'b01;
          branch  = 1'b1;
          retire  = 1'b1;
        end
        S_TRAP: begin
          trap = 1'b1;
        end
        default: begin
          trap = 1'b1;
        end
      endcase
    end
  end

  assign pcW = pcUpdate | (branch & bus.zero);

  assign bus.mem_req    = memReq;
  assign bus.mem_w      = memW;
  assign bus.adr_src    = adrSrc;
  assign bus.ir_w       = irW;
  assign bus.pc_w       = pcW;
  assign bus.reg_w      = regW;
  assign bus.alu_src_a  = aluSrcA;
  assign bus.alu_src_b  = aluSrcB;
  assign bus.alu_op     = aluOp;
  assign bus.result_src = resultSrc;
  assign bus.imm_src    = immSrc;
  assign bus.retire     = retire;
  assign bus.trap       = trap;

endmodule
